// File: rtl/cpu54_pkg.sv
// Shared definitions for the CPU54 front end: pc_sel encodings, vectors,
// sequencer FSM states and the next-PC select payload.
package cpu54_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SELW  = 3;
  localparam int unsigned IDXW  = 26;

  localparam logic [SELW-1:0] PCSEL_SEQ  = 3'd0;
  localparam logic [SELW-1:0] PCSEL_BR   = 3'd1;
  localparam logic [SELW-1:0] PCSEL_J    = 3'd2;
  localparam logic [SELW-1:0] PCSEL_JR   = 3'd3;
  localparam logic [SELW-1:0] PCSEL_ERET = 3'd4;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR   = 32'h0040_0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] next_pc;
    logic            take_exc;
    logic            addr_err;
  } npc_sel_t;

endpackage

// File: rtl/npc_sequencer_if.sv
// Decode/regfile/imem-facing bundle of the PC sequencer.
interface npc_sequencer_if;
  import cpu54_pkg::*;

  logic            stall;
  logic [SELW-1:0] pc_sel;
  logic            br_taken;
  logic [XLEN-1:0] br_offset;
  logic [IDXW-1:0] instr_index;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] epc_in;
  logic            exc_req;
  logic [XLEN-1:0] pc;
  logic            fetch_en;
  logic [XLEN-1:0] link_addr;
  logic            epc_wr;
  logic [XLEN-1:0] epc_val;
  logic            addr_err;

  modport master (
    output stall, pc_sel, br_taken, br_offset, instr_index, rs_data, epc_in, exc_req,
    input  pc, fetch_en, link_addr, epc_wr, epc_val, addr_err
  );

  modport slave (
    input  stall, pc_sel, br_taken, br_offset, instr_index, rs_data, epc_in, exc_req,
    output pc, fetch_en, link_addr, epc_wr, epc_val, addr_err
  );
endinterface

// File: rtl/npc_mux.sv
// Combinational next-PC target computation and priority select.
module npc_mux
  import cpu54_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [XLEN-1:0] pc,
  input  logic [SELW-1:0] pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic [IDXW-1:0] instr_index,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] epc_in,
  input  logic            exc,
  output npc_sel_t        sel_c,
  output logic [XLEN-1:0] link_addr
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic            jr_misaligned;
  logic            take_exc;

  assign pc_plus4      = pc + XLEN'(4);
  assign br_target     = pc_plus4 + (br_offset << 2);
  assign j_target      = {pc_plus4[XLEN-1:XLEN-4], instr_index, 2'b00};
  assign jr_misaligned = (pc_sel == PCSEL_JR) && (rs_data[1:0] != 2'b00);
  assign take_exc      = exc | jr_misaligned;
  assign link_addr     = pc_plus4;

  // Exception entry outranks every pc_sel source; unknown encodings fall to SEQ.
  always_comb begin
    sel_c          = '0;
    sel_c.take_exc = take_exc;
    sel_c.addr_err = jr_misaligned;
    sel_c.next_pc  = pc_plus4;
    if (take_exc) begin
      sel_c.next_pc = EXC_VECTOR;
    end else begin
      case (pc_sel)
        PCSEL_ERET: sel_c.next_pc = epc_in;
        PCSEL_JR:   sel_c.next_pc = rs_data;
        PCSEL_J:    sel_c.next_pc = j_target;
        PCSEL_BR:   if (br_taken) sel_c.next_pc = br_target;
        default:    sel_c.next_pc = pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/npc_sequencer.sv
// CPU54 program-counter sequencer: owns the PC, stalls for mul/div and
// defers exceptions that arrive while stalled.
module npc_sequencer
  import cpu54_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input logic            clk,
  input logic            rst,
  npc_sequencer_if.slave bus
);

  seq_state_e      state, state_n;
  npc_sel_t        npc_c;
  logic [XLEN-1:0] link_c;
  logic            advance_c;
  logic            exc_pend;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] pc_q;
  logic            epc_wr_q;
  logic [XLEN-1:0] epc_val_q;
  logic            addr_err_q;

  // The cycle stall drops in HOLD already behaves as RUN, so both states advance alike.
  assign advance_c = (state != ST_BOOT) && !bus.stall;

  npc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_mux (
    .pc          (pc_q),
    .pc_sel      (bus.pc_sel),
    .br_taken    (bus.br_taken),
    .br_offset   (bus.br_offset),
    .instr_index (bus.instr_index),
    .rs_data     (bus.rs_data),
    .epc_in      (bus.epc_in),
    .exc         (bus.exc_req | exc_pend),
    .sel_c       (npc_c),
    .link_addr   (link_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_BOOT: state_n = ST_RUN;
      ST_RUN:  if (bus.stall)  state_n = ST_HOLD;
      ST_HOLD: if (!bus.stall) state_n = ST_RUN;
      default: state_n = ST_BOOT;
    endcase
  end

  // PC, EPC report and the deferred-exception capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      epc_wr_q   <= 1'b0;
      epc_val_q  <= '0;
      addr_err_q <= 1'b0;
      exc_pend   <= 1'b0;
      pend_pc    <= '0;
    end else begin
      epc_wr_q   <= 1'b0;
      addr_err_q <= 1'b0;
      if (advance_c) begin
        pc_q <= npc_c.next_pc;
        if (npc_c.take_exc) begin
          epc_wr_q   <= 1'b1;
          epc_val_q  <= exc_pend ? pend_pc : pc_q;
          addr_err_q <= npc_c.addr_err;
        end
        exc_pend <= 1'b0;
      end else if (state != ST_BOOT && bus.exc_req && !exc_pend) begin
        exc_pend <= 1'b1;
        pend_pc  <= pc_q;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.fetch_en  = advance_c;
  assign bus.link_addr = link_c;
  assign bus.epc_wr    = epc_wr_q;
  assign bus.epc_val   = epc_val_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed vector table, reset corner
// sequences, then random stimulus against a behavioural model.
module tb_npc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  npc_sequencer_if bif ();

  npc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  sel;
    logic        taken;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        exc;
    logic        exp_fetch;
    logic [31:0] exp_link;
    logic [31:0] exp_pc;
    logic        exp_wr;
    logic        exp_ae;
    logic [31:0] exp_ev;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic [2:0] sel, logic tk, logic [31:0] off,
                              logic [25:0] idx, logic [31:0] rs, logic [31:0] epc, logic exc,
                              logic f, logic [31:0] lnk, logic [31:0] pc, logic wr,
                              logic ae, logic [31:0] ev);
    vec_t v;
    v.stall = st; v.sel = sel; v.taken = tk; v.off = off; v.idx = idx; v.rs = rs;
    v.epc = epc; v.exc = exc; v.exp_fetch = f; v.exp_link = lnk; v.exp_pc = pc;
    v.exp_wr = wr; v.exp_ae = ae; v.exp_ev = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] sel, input logic tk, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] epc,
                       input logic exc);
    bif.stall = st; bif.pc_sel = sel; bif.br_taken = tk; bif.br_offset = off;
    bif.instr_index = idx; bif.rs_data = rs; bif.epc_in = epc; bif.exc_req = exc;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state for the random phase.
  logic        m_boot;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  logic [31:0] m_ev;

  initial begin
    idle();
    // Reset state
    tick(); tick();
    chk("rst_pc", bif.pc, RV);
    chk("rst_fetch", 32'(bif.fetch_en), 32'd0);
    chk("rst_epc_wr", 32'(bif.epc_wr), 32'd0);
    chk("rst_epc_val", bif.epc_val, 32'd0);
    chk("rst_addr_err", 32'(bif.addr_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("boot_fetch", 32'(bif.fetch_en), 32'd0);
    tick();
    chk("boot_pc", bif.pc, RV);

    // st sel tk off idx rs epc exc | fetch link pc wr ae ev
    vq.push_back(mk(0,3'd0,0,0,0,0,0,0, 1,32'h00400004,32'h00400004,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400010,0,0, 1,32'h00400008,32'h00400010,0,0,0));
    vq.push_back(mk(0,3'd1,1,32'hFFFFFFFE,0,0,0,0, 1,32'h00400014,32'h0040000C,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400010,0,0, 1,32'h00400010,32'h00400010,0,0,0));
    vq.push_back(mk(0,3'd1,0,32'hFFFFFFFE,0,0,0,0, 1,32'h00400014,32'h00400014,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400020,0,0, 1,32'h00400018,32'h00400020,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400100,0,0, 1,32'h00400024,32'h00400100,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400020,0,0, 1,32'h00400104,32'h00400020,0,0,0));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00400102,0,0, 1,32'h00400024,EV,1,1,32'h00400020));
    vq.push_back(mk(0,3'd0,0,0,0,0,0,0, 1,32'h00400008,32'h00400008,0,0,32'h00400020));
    vq.push_back(mk(0,3'd4,0,0,0,0,32'h00400040,0, 1,32'h0040000C,32'h00400040,0,0,32'h00400020));
    vq.push_back(mk(0,3'd3,0,0,0,32'hF0000000,0,0, 1,32'h00400044,32'hF0000000,0,0,32'h00400020));
    vq.push_back(mk(0,3'd2,0,0,26'h10,0,0,0, 1,32'hF0000004,32'hF0000040,0,0,32'h00400020));
    vq.push_back(mk(0,3'd0,0,0,0,0,0,1, 1,32'hF0000044,EV,1,0,32'hF0000040));
    vq.push_back(mk(0,3'd3,0,0,0,32'h00000003,0,1, 1,32'h00400008,EV,1,1,32'h00400004));
    vq.push_back(mk(0,3'd4,0,0,0,0,32'h00400040,0, 1,32'h00400008,32'h00400040,0,0,32'h00400004));
    vq.push_back(mk(1,3'd0,0,0,0,0,0,0, 0,32'h00400044,32'h00400040,0,0,32'h00400004));
    vq.push_back(mk(1,3'd0,0,0,0,0,0,1, 0,32'h00400044,32'h00400040,0,0,32'h00400004));
    vq.push_back(mk(1,3'd0,0,0,0,0,0,0, 0,32'h00400044,32'h00400040,0,0,32'h00400004));
    vq.push_back(mk(0,3'd0,0,0,0,0,0,0, 1,32'h00400044,EV,1,0,32'h00400040));
    vq.push_back(mk(0,3'd0,0,0,0,0,0,0, 1,32'h00400008,32'h00400008,0,0,32'h00400040));
    vq.push_back(mk(0,3'd3,0,0,0,32'hFFFFFFFC,0,0, 1,32'h0040000C,32'hFFFFFFFC,0,0,32'h00400040));
    vq.push_back(mk(0,3'd0,0,0,0,0,0,0, 1,32'h00000000,32'h00000000,0,0,32'h00400040));
    vq.push_back(mk(0,3'd7,0,0,0,0,0,0, 1,32'h00000004,32'h00000004,0,0,32'h00400040));

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].sel, vq[i].taken, vq[i].off, vq[i].idx, vq[i].rs, vq[i].epc, vq[i].exc);
      @(negedge clk);
      chk($sformatf("v%0d_fetch", i), 32'(bif.fetch_en), 32'(vq[i].exp_fetch));
      chk($sformatf("v%0d_link", i), bif.link_addr, vq[i].exp_link);
      tick();
      chk($sformatf("v%0d_pc", i), bif.pc, vq[i].exp_pc);
      chk($sformatf("v%0d_epc_wr", i), 32'(bif.epc_wr), 32'(vq[i].exp_wr));
      chk($sformatf("v%0d_addr_err", i), 32'(bif.addr_err), 32'(vq[i].exp_ae));
      chk($sformatf("v%0d_epc_val", i), bif.epc_val, vq[i].exp_ev);
    end

    // Async reset mid-HOLD with an exception pending
    drive(1'b1, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 32'd0, 1'b0);
    tick();
    bif.exc_req = 1'b1;
    tick();
    bif.exc_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("hold_rst_pc", bif.pc, RV);
    chk("hold_rst_epc_wr", 32'(bif.epc_wr), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("hold_rst_boot_fetch", 32'(bif.fetch_en), 32'd0);
    tick();
    chk("hold_rst_boot_pc", bif.pc, RV);
    tick();
    chk("hold_rst_seq_pc", bif.pc, RV + 32'd4);
    chk("hold_rst_no_epc_wr", 32'(bif.epc_wr), 32'd0);
    tick();
    chk("hold_rst_no_epc_wr2", 32'(bif.epc_wr), 32'd0);

    // Async reset while the epc_wr pulse is high
    bif.exc_req = 1'b1;
    tick();
    bif.exc_req = 1'b0;
    chk("pulse_epc_wr", 32'(bif.epc_wr), 32'd1);
    chk("pulse_epc_val", bif.epc_val, RV + 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("pulse_rst_epc_wr", 32'(bif.epc_wr), 32'd0);
    chk("pulse_rst_epc_val", bif.epc_val, 32'd0);
    tick();
    rst = 1'b0;

    // Random stimulus against the model
    m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = '0; m_pc = RV; m_ev = '0;
    for (int n = 0; n < 3000; n++) begin
      logic        st, tk, ex, fe, wr, ae, mis, take;
      logic [2:0]  sel;
      logic [31:0] off, rs, epc, nxt;
      logic [25:0] idx;
      st  = ($urandom_range(0, 3) == 0);
      sel = 3'($urandom_range(0, 7));
      tk  = 1'($urandom);
      off = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
      idx = 26'($urandom);
      rs  = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      epc = $urandom;
      ex  = ($urandom_range(0, 9) == 0);
      drive(st, sel, tk, off, idx, rs, epc, ex);

      nxt = m_pc; fe = 1'b0; wr = 1'b0; ae = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (st) begin
        if (ex && !m_pend) begin
          m_pend = 1'b1;
          m_pend_pc = m_pc;
        end
      end else begin
        fe   = 1'b1;
        mis  = (sel == 3'd3) && (rs % 4 != 0);
        take = ex || m_pend || mis;
        if (take)                  nxt = EV;
        else if (sel == 3'd4)      nxt = epc;
        else if (sel == 3'd3)      nxt = rs;
        else if (sel == 3'd2)      nxt = ((m_pc + 32'd4) & 32'hF000_0000) + {4'd0, idx, 2'b00};
        else if (sel == 3'd1 && tk) nxt = m_pc + 32'd4 + off * 32'd4;
        else                       nxt = m_pc + 32'd4;
        if (take) begin
          wr   = 1'b1;
          ae   = mis;
          m_ev = m_pend ? m_pend_pc : m_pc;
        end
        m_pend = 1'b0;
      end

      @(negedge clk);
      chk("rnd_fetch", 32'(bif.fetch_en), 32'(fe));
      chk("rnd_link", bif.link_addr, m_pc + 32'd4);
      tick();
      m_pc = nxt;
      chk("rnd_pc", bif.pc, m_pc);
      chk("rnd_epc_wr", 32'(bif.epc_wr), 32'(wr));
      chk("rnd_addr_err", 32'(bif.addr_err), 32'(ae));
      chk("rnd_epc_val", bif.epc_val, m_ev);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
